branch_resolve: RTL

//   Execute-stage branch resolution unit; the producer end of the fetch redirect/prediction-feedback interface.

---
 rtl/branch_resolve.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch resolution unit.
// Evaluates conditional branches, JAL and JALR against the path fetch took
// (pred_pc) and drives fetch's redirect / prediction-feedback inputs. On a
// mispredict a small squash FSM holds flush high for FLUSH_CYCLES cycles.
//
// State table:
//   state   | meaning
//   S_IDLE  | normal operation, resolving control transfers
//   S_FLUSH | squashing wrong-path instructions, down-counter running
//
// Ports:
//   clk, reset (sync, active-low)
//   valid_e, stall_e, is_br, is_jal, is_jalr, funct3   execute-stage control
//   rs1_val, rs2_val, pc_e, imm_e, pred_pc              execute-stage operands
//   branch_sig, branch_pc, branch_plus4                 resolved direction/targets (held)
//   success, failure, branch                            one-cycle feedback pulses
//   flush                                               squash decode/execute
//   cnt_branch, cnt_miss                                wrapping event counters
module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_e,
    input  logic             stall_e,
    input  logic             is_br,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic [2:0]       funct3,
    input  logic [31:0]      rs1_val,
    input  logic [31:0]      rs2_val,
    input  logic [31:0]      pc_e,
    input  logic [31:0]      imm_e,
    input  logic [31:0]      pred_pc,
    output logic             branch_sig,
    output logic [31:0]      branch_pc,
    output logic [31:0]      branch_plus4,
    output logic             success,
    output logic             failure,
    output logic             branch,
    output logic             flush,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_miss
);

    typedef enum logic {S_IDLE, S_FLUSH} state_t;

    // flush is already high in the failure cycle, so the counter is loaded
    // with the number of remaining cycles.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t      state, state_nxt;
    logic [3:0]  fcnt, fcnt_nxt;
    logic        flush_nxt;

    logic        cond, taken, mispredict, resolve;
    logic [31:0] target, plus4, actual_npc;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            3'b000:  cond = (rs1_val == rs2_val);
            3'b001:  cond = (rs1_val != rs2_val);
            3'b100:  cond = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  cond = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  cond = (rs1_val <  rs2_val);
            3'b111:  cond = (rs1_val >= rs2_val);
            default: cond = 1'b0;
        endcase
    end

    assign plus4      = pc_e + 32'd4;
    assign target     = is_jalr ? ((rs1_val + imm_e) & ~32'h1) : (pc_e + imm_e);
    assign taken      = is_jal | is_jalr | (is_br & cond);
    assign actual_npc = taken ? target : plus4;
    assign mispredict = (actual_npc != pred_pc);
    // Instructions arriving while flush is high are on the wrong path.
    assign resolve    = valid_e & ~stall_e & ~flush & (is_br | is_jal | is_jalr);

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        flush_nxt = flush;
        case (state)
            S_IDLE: begin
                if (resolve && mispredict) begin
                    state_nxt = S_FLUSH;
                    fcnt_nxt  = FLUSH_LOAD;
                    flush_nxt = 1'b1;
                end
            end
            S_FLUSH: begin
                // Counts regardless of stall_e.
                if (fcnt == 4'd0) begin
                    state_nxt = S_IDLE;
                    flush_nxt = 1'b0;
                end else begin
                    fcnt_nxt = fcnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                flush_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            fcnt         <= 4'd0;
            flush        <= 1'b0;
            branch_sig   <= 1'b0;
            branch_pc    <= 32'd0;
            branch_plus4 <= 32'd0;
            success      <= 1'b0;
            failure      <= 1'b0;
            branch       <= 1'b0;
            cnt_branch   <= '0;
            cnt_miss     <= '0;
        end else begin
            state   <= state_nxt;
            fcnt    <= fcnt_nxt;
            flush   <= flush_nxt;
            success <= resolve & is_br & ~mispredict;
            failure <= resolve & mispredict;
            branch  <= resolve & is_br & taken;
            if (resolve) begin
                branch_sig   <= taken;
                branch_pc    <= target;
                branch_plus4 <= plus4;
                cnt_branch   <= cnt_branch + CNT_ONE;
                if (mispredict) begin
                    cnt_miss <= cnt_miss + CNT_ONE;
                end
            end
        end
    end

endmodule
